effect_channel_mux: RTL and testbench

Single-clock successor to the two-channel effect controller: accepts one audio frame of CHANNELS received I2S samples, routes each channel in turn through the shared effect pipeline with a valid/ready handshake, and returns a reassembled output frame for the I2S transmitter. Supports per-channel bypass, a per-request response timeout with dry-sample substitution, and overrun/timeout status flags. Sits between the I2S receive/transmit data registers and the effect module, in the 25 MHz `clk` domain.

---
 rtl/effects_pkg.sv | 26 ++
 rtl/sample_format.sv | 27 ++
 rtl/effect_channel_mux.sv | 134 +++++++++++++
 tb/tb_effect_channel_mux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/effects_pkg.sv
// Shared definitions for the effect-channel controllers: FSM encoding,
// default sample widths and width helpers.
package effects_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_D_WIDTH     = 24;
    localparam int DEF_MEM_D_WIDTH = 16;
    localparam int DEF_TIMEOUT     = 1024;

    // Timer must be able to count 0..timeout inclusive.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int pad_width(input int d_width, input int mem_d_width);
        return d_width - mem_d_width;
    endfunction

endpackage

// File: rtl/sample_format.sv
// Combinational sample width conversion between the I2S word (D_WIDTH)
// and the effect/memory word (MEM_D_WIDTH).
module sample_format
    import effects_pkg::*;
#(
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int MEM_D_WIDTH = DEF_MEM_D_WIDTH
) (
    input  logic [D_WIDTH-1:0]     i_wide,
    output logic [MEM_D_WIDTH-1:0] o_narrow,
    input  logic [MEM_D_WIDTH-1:0] i_narrow,
    output logic [D_WIDTH-1:0]     o_wide
);

    localparam int PAD = pad_width(D_WIDTH, MEM_D_WIDTH);

    assign o_narrow = i_wide[D_WIDTH-1 -: MEM_D_WIDTH];

    generate
        if (PAD > 0) begin : g_pad
            assign o_wide = {i_narrow, {PAD{1'b0}}};
        end else begin : g_nopad
            assign o_wide = i_narrow;
        end
    endgenerate

endmodule

// File: rtl/effect_channel_mux.sv
// Routes each channel of a captured audio frame through the shared effect
// pipeline one at a time and returns the reassembled frame.
module effect_channel_mux
    import effects_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int MEM_D_WIDTH = DEF_MEM_D_WIDTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_frame_valid,
    input  logic [CHANNELS*D_WIDTH-1:0]  i_frame,
    input  logic [CHANNELS-1:0]          i_bypass,
    input  logic                         i_clear,
    output logic [MEM_D_WIDTH-1:0]       o_eff_data,
    output logic                         o_eff_valid,
    input  logic                         i_eff_ready,
    input  logic [MEM_D_WIDTH-1:0]       i_eff_data,
    input  logic                         i_eff_valid,
    output logic [CHANNELS*D_WIDTH-1:0]  o_frame,
    output logic                         o_frame_valid,
    output logic                         o_busy,
    output logic                         o_overrun,
    output logic                         o_timeout
);

    localparam int TW = timer_width(TIMEOUT);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t                             r_state, w_state_nxt;
    logic [CW-1:0]                      r_ch;
    logic [TW-1:0]                      r_timer;
    logic [CHANNELS-1:0][D_WIDTH-1:0]   r_in, r_res, r_out, w_res_nxt;
    logic [CHANNELS-1:0]                r_bypass;
    logic                               r_frame_valid, r_overrun, r_timeout;

    logic [D_WIDTH-1:0]     w_cur_in, w_resp_wide, w_ch_result;
    logic [MEM_D_WIDTH-1:0] w_cur_narrow;
    logic w_byp_cur, w_last, w_hs, w_resp, w_tmo, w_adv, w_ovr;

    sample_format #(.D_WIDTH(D_WIDTH), .MEM_D_WIDTH(MEM_D_WIDTH)) u_fmt (
        .i_wide   (w_cur_in),
        .o_narrow (w_cur_narrow),
        .i_narrow (i_eff_data),
        .o_wide   (w_resp_wide)
    );

    assign w_cur_in  = r_in[r_ch];
    assign w_byp_cur = r_bypass[r_ch];
    assign w_last    = (r_ch == CW'(CHANNELS - 1));
    assign w_hs      = (r_state == ST_SEND) && !w_byp_cur && i_eff_ready;
    // A response in the final timer cycle takes priority over the timeout.
    assign w_resp    = (r_state == ST_WAIT) && i_eff_valid;
    assign w_tmo     = (r_state == ST_WAIT) && !i_eff_valid && (r_timer == TW'(TIMEOUT - 1));
    assign w_adv     = ((r_state == ST_SEND) && w_byp_cur) || w_resp || w_tmo;
    assign w_ch_result = w_resp ? w_resp_wide : w_cur_in;
    assign w_ovr     = i_frame_valid && (r_state != ST_IDLE);

    always_comb begin
        w_res_nxt = r_res;
        if (w_adv) w_res_nxt[r_ch] = w_ch_result;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_frame_valid) w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (w_adv)     w_state_nxt = w_last ? ST_DONE : ST_SEND;
                else if (w_hs) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: if (w_adv) w_state_nxt = w_last ? ST_DONE : ST_SEND;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_eff_valid = (r_state == ST_SEND) && !w_byp_cur;
        o_eff_data  = o_eff_valid ? w_cur_narrow : '0;
        o_busy      = (r_state != ST_IDLE);
    end

    // o_frame is loaded with the final channel merged in, so it and its strobe
    // become visible together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch          <= '0;
            r_timer       <= '0;
            r_in          <= '0;
            r_res         <= '0;
            r_out         <= '0;
            r_bypass      <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if ((r_state == ST_IDLE) && i_frame_valid) begin
                r_in     <= i_frame;
                r_bypass <= i_bypass;
                r_ch     <= '0;
            end
            if (w_hs)                     r_timer <= '0;
            else if (r_state == ST_WAIT)  r_timer <= r_timer + 1'b1;
            if (w_adv) begin
                r_res <= w_res_nxt;
                if (w_last) begin
                    r_out         <= w_res_nxt;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
            if (w_ovr)        r_overrun <= 1'b1;
            else if (i_clear) r_overrun <= 1'b0;
            if (w_tmo)        r_timeout <= 1'b1;
            else if (i_clear) r_timeout <= 1'b0;
        end
    end

    assign o_frame       = r_out;
    assign o_frame_valid = r_frame_valid;
    assign o_overrun     = r_overrun;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_effect_channel_mux.sv
// Directed bench for effect_channel_mux with CHANNELS=2 and TIMEOUT=16.
module tb_effect_channel_mux;

    localparam int CH = 2;
    localparam int DW = 24;
    localparam int MW = 16;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               i_frame_valid = 1'b0;
    logic [CH*DW-1:0]   i_frame = '0;
    logic [CH-1:0]      i_bypass = '0;
    logic               i_clear = 1'b0;
    logic [MW-1:0]      o_eff_data;
    logic               o_eff_valid;
    logic               i_eff_ready = 1'b0;
    logic [MW-1:0]      i_eff_data = '0;
    logic               i_eff_valid = 1'b0;
    logic [CH*DW-1:0]   o_frame;
    logic               o_frame_valid;
    logic               o_busy;
    logic               o_overrun;
    logic               o_timeout;

    int n_chk = 0;
    int n_err = 0;

    effect_channel_mux #(.CHANNELS(CH), .D_WIDTH(DW), .MEM_D_WIDTH(MW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_frame_valid (i_frame_valid),
        .i_frame       (i_frame),
        .i_bypass      (i_bypass),
        .i_clear       (i_clear),
        .o_eff_data    (o_eff_data),
        .o_eff_valid   (o_eff_valid),
        .i_eff_ready   (i_eff_ready),
        .i_eff_data    (i_eff_data),
        .i_eff_valid   (i_eff_valid),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [CH*DW-1:0] f, input logic [CH-1:0] b);
        i_frame = f;
        i_bypass = b;
        i_frame_valid = 1'b1;
        tick();
        i_frame_valid = 1'b0;
    endtask

    // Called in a SEND cycle with i_eff_ready high; responds on the 3rd WAIT cycle.
    task automatic serve(input logic [MW-1:0] exp_eff, input logic [MW-1:0] resp, input string tag);
        chk({tag, "_eff_valid"}, o_eff_valid, 1);
        chk({tag, "_eff_data"}, o_eff_data, exp_eff);
        tick();
        chk({tag, "_wait_entry"}, o_eff_valid, 0);
        tick();
        tick();
        i_eff_valid = 1'b1;
        i_eff_data = resp;
        tick();
        i_eff_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_frame", o_frame, 0);
        chk("rst_fvalid", o_frame_valid, 0);
        chk("rst_eff_valid", o_eff_valid, 0);
        chk("rst_eff_data", o_eff_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_flags", {o_overrun, o_timeout}, 0);
        reset = 1'b0;
        tick();

        // All-bypass frame: result at T+3, no effect traffic
        start({24'h123456, 24'hABCDEF}, 2'b11);
        chk("byp_busy", o_busy, 1);
        chk("byp_eff0", o_eff_valid, 0);
        chk("byp_fv0", o_frame_valid, 0);
        tick();
        chk("byp_eff1", o_eff_valid, 0);
        chk("byp_fv1", o_frame_valid, 0);
        tick();
        chk("byp_fv", o_frame_valid, 1);
        chk("byp_frame", o_frame, {24'h123456, 24'hABCDEF});
        tick();
        chk("byp_fv_off", o_frame_valid, 0);
        chk("byp_hold", o_frame, {24'h123456, 24'hABCDEF});
        chk("byp_idle", o_busy, 0);

        // Both channels through the effect, echo after 3 cycles
        i_eff_ready = 1'b1;
        start({24'h123456, 24'h7FFF80}, 2'b00);
        serve(16'h7FFF, 16'h7FFF, "eff_ch0");
        serve(16'h1234, 16'h1234, "eff_ch1");
        chk("eff_fv", o_frame_valid, 1);
        chk("eff_frame", o_frame, {24'h123400, 24'h7FFF00});
        tick();

        // Ready held low: request must stay stable
        i_eff_ready = 1'b0;
        start({24'hAAAAAA, 24'h89ABCD}, 2'b10);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", o_eff_valid, 1);
            chk("stall_data", o_eff_data, 16'h89AB);
            tick();
        end
        i_eff_ready = 1'b1;
        serve(16'h89AB, 16'h5555, "stall");
        chk("stall_ch1_byp", o_eff_valid, 0);
        tick();
        chk("stall_fv", o_frame_valid, 1);
        chk("stall_frame", o_frame, {24'hAAAAAA, 24'h555500});
        tick();

        // Timeout on ch0: dry sample substituted, late response ignored
        start({24'h0F0F0F, 24'h246813}, 2'b10);
        chk("tmo_eff_data", o_eff_data, 16'h2468);
        tick();
        repeat (15) tick();
        chk("tmo_before", o_timeout, 0);
        chk("tmo_busy", o_busy, 1);
        tick();
        chk("tmo_set", o_timeout, 1);
        i_eff_valid = 1'b1;
        i_eff_data = 16'hFFFF;
        tick();
        i_eff_valid = 1'b0;
        chk("tmo_fv", o_frame_valid, 1);
        chk("tmo_frame", o_frame, {24'h0F0F0F, 24'h246813});
        tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("tmo_clear", o_timeout, 0);

        // Overrun: second frame while busy is dropped
        chk("ovr_before", o_overrun, 0);
        start({24'h111111, 24'h222222}, 2'b11);
        i_frame = {24'h333333, 24'h444444};
        i_bypass = 2'b00;
        i_frame_valid = 1'b1;
        tick();
        i_frame_valid = 1'b0;
        chk("ovr_set", o_overrun, 1);
        chk("ovr_byp_kept", o_eff_valid, 0);
        tick();
        chk("ovr_fv", o_frame_valid, 1);
        chk("ovr_frame", o_frame, {24'h111111, 24'h222222});
        i_frame_valid = 1'b1;
        i_clear = 1'b1;
        tick();
        i_frame_valid = 1'b0;
        i_clear = 1'b0;
        chk("ovr_set_wins", o_overrun, 1);
        chk("ovr_dropped", o_busy, 0);
        tick();
        chk("ovr_still_idle", {o_busy, o_frame_valid}, 0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("ovr_clear", o_overrun, 0);

        // Reset while waiting on the effect
        start({24'h000000, 24'h765432}, 2'b00);
        tick();
        tick();
        chk("rw_busy", o_busy, 1);
        reset = 1'b1;
        tick();
        chk("rw_eff_valid", o_eff_valid, 0);
        chk("rw_eff_data", o_eff_data, 0);
        chk("rw_busy0", o_busy, 0);
        chk("rw_frame", o_frame, 0);
        chk("rw_fv", o_frame_valid, 0);
        reset = 1'b0;
        tick();
        start({24'hC0FFEE, 24'h000001}, 2'b01);
        tick();
        serve(16'hC0FF, 16'hC0FF, "rw_ch1");
        chk("rw_after_fv", o_frame_valid, 1);
        chk("rw_after_frame", o_frame, {24'hC0FF00, 24'h000001});
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
